// File: rtl/stack_port_arbiter_if.sv
// Requester-side bus for stack_port_arbiter: two req/op/data channels and
// the shared done/err/rd_data return path.
interface stack_port_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             done0;
  logic             done1;
  logic             err;
  logic [WIDTH-1:0] rd_data;

  // Requester side
  modport master (
    output req0, req1, op0, op1, data0, data1,
    input  done0, done1, err, rd_data
  );

  // Arbiter side
  modport slave (
    input  req0, req1, op0, op1, data0, data1,
    output done0, done1, err, rd_data
  );
endinterface

// File: rtl/stack_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the stack register.
// Grants one requester at a time, pulses stk_move for exactly one cycle on
// PUSH/POP, tracks occupancy and refuses overflow/underflow.
// Optional feature macro: STACK_ARB_PEEK_EN (op 11 = PEEK when defined,
// otherwise op 11 decodes as NOP).
module stack_port_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  stack_port_arbiter_if.slave            bus,
  output logic                           stk_move,
  output logic                           stk_mode,
  output logic [WIDTH-1:0]               stk_in_word,
  input  logic [WIDTH-1:0]               stk_top_word,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
  localparam logic [DW-1:0] DepthOne = DW'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExec   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;
  localparam logic [1:0] OpPeek = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_flag_q, err_flag_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             stk_move_q, stk_move_d;
  logic             stk_mode_q, stk_mode_d;
  logic [WIDTH-1:0] stk_in_word_q, stk_in_word_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             grant;

  // Next-state logic for the sequencer FSM and all registered outputs.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    op_d          = op_q;
    data_d        = data_q;
    err_flag_d    = err_flag_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    err_d         = 1'b0;
    rd_data_d     = rd_data_q;
    stk_move_d    = 1'b0;
    stk_mode_d    = stk_mode_q;
    stk_in_word_d = stk_in_word_q;
    depth_d       = depth_q;
    grant         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Contention resolved by rr; a lone requester wins outright.
          grant      = (bus.req0 && bus.req1) ? rr_q : bus.req1;
          owner_d    = grant;
          op_d       = grant ? bus.op1 : bus.op0;
          data_d     = grant ? bus.data1 : bus.data0;
          err_flag_d = 1'b0;
          state_d    = StExec;
        end
      end
      StExec: begin
        state_d = StDone;
        case (op_q)
          OpPush: begin
            if (full_q) begin
              err_flag_d = 1'b1;
            end else begin
              stk_move_d    = 1'b1;
              stk_mode_d    = 1'b1;
              stk_in_word_d = data_q;
              depth_d       = depth_q + DepthOne;
              state_d       = StSettle;
            end
          end
          OpPop: begin
            if (empty_q) begin
              err_flag_d = 1'b1;
            end else begin
              // Top is captured before the move takes effect.
              rd_data_d  = stk_top_word;
              stk_move_d = 1'b1;
              stk_mode_d = 1'b0;
              depth_d    = depth_q - DepthOne;
              state_d    = StSettle;
            end
          end
`ifdef STACK_ARB_PEEK_EN
          OpPeek: begin
            if (empty_q) begin
              err_flag_d = 1'b1;
            end else begin
              rd_data_d = stk_top_word;
            end
          end
`else
          OpPeek: begin
            // PEEK disabled: behaves as NOP.
          end
`endif
          OpNop: begin
          end
          default: begin
          end
        endcase
      end
      StSettle: begin
        // stk_move defaults low here, bounding the strobe to one cycle.
        state_d = StDone;
      end
      StDone: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        err_d   = err_flag_q;
        rr_d    = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    full_d  = (depth_d == DepthMax);
    empty_d = (depth_d == '0);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      op_q          <= OpNop;
      data_q        <= '0;
      err_flag_q    <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
      stk_move_q    <= 1'b0;
      stk_mode_q    <= 1'b0;
      stk_in_word_q <= '0;
      depth_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      data_q        <= data_d;
      err_flag_q    <= err_flag_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      stk_move_q    <= stk_move_d;
      stk_mode_q    <= stk_mode_d;
      stk_in_word_q <= stk_in_word_d;
      depth_q       <= depth_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
    end
  end

  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;
  assign stk_move    = stk_move_q;
  assign stk_mode    = stk_mode_q;
  assign stk_in_word = stk_in_word_q;
  assign depth       = depth_q;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed bench for stack_port_arbiter: handshake latency, move strobes,
// round-robin order, full/empty refusal and mid-operation reset.
module tb_stack_port_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;
  localparam logic [1:0] OpPeek = 2'b11;
`ifdef STACK_ARB_PEEK_EN
  localparam bit PeekEn = 1'b1;
`else
  localparam bit PeekEn = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             stk_move;
  logic             stk_mode;
  logic [WIDTH-1:0] stk_in_word;
  logic [WIDTH-1:0] stk_top_word;
  logic [3:0]       depth;
  logic             full;
  logic             empty;

  int checks = 0;
  int failures = 0;

  stack_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  stack_port_arbiter #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stk_move    (stk_move),
    .stk_mode    (stk_mode),
    .stk_in_word (stk_in_word),
    .stk_top_word(stk_top_word),
    .depth       (depth),
    .full        (full),
    .empty       (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one op and measure done latency (edges after the sampling edge).
  task automatic do_op(input string tag, input int port, input logic [1:0] op,
                       input logic [3:0] dat, input int exp_lat, input logic exp_err,
                       input int exp_moves, input logic exp_mode);
    int         lat;
    int         moves;
    logic       e;
    logic       mode_seen;
    logic [3:0] in_seen;
    bit         got;
    @(negedge clk);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.data0 = dat;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.data1 = dat;
    end
    got = 1'b0; lat = -1; moves = 0; e = 1'b0; mode_seen = 1'b0; in_seen = '0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk);
      #1;
      if (stk_move) begin
        moves++;
        mode_seen = stk_mode;
        in_seen   = stk_in_word;
      end
      if ((port == 0 && bus.done0) || (port == 1 && bus.done1)) begin
        got = 1'b1;
        lat = c - 1;
        e   = bus.err;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, e, exp_err);
    check({tag, "_moves"}, moves, exp_moves);
    if (exp_moves > 0) check({tag, "_mode"}, mode_seen, exp_mode);
    if (exp_moves > 0 && exp_mode) check({tag, "_in_word"}, in_seen, dat);
  endtask

  // Both ports push in the same cycle; port 0 must be served first.
  task automatic dual_push(input string tag, input logic [3:0] d0, input logic [3:0] d1);
    int         t0;
    int         t1;
    int         nm;
    logic [3:0] first_in;
    logic [3:0] second_in;
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = OpPush; bus.data0 = d0;
    bus.req1 = 1'b1; bus.op1 = OpPush; bus.data1 = d1;
    t0 = -1; t1 = -1; nm = 0; first_in = '0; second_in = '0;
    for (int c = 1; c <= 20 && (t0 < 0 || t1 < 0); c++) begin
      @(posedge clk);
      #1;
      if (stk_move) begin
        if (nm == 0) first_in = stk_in_word;
        else second_in = stk_in_word;
        nm++;
      end
      if (bus.done0 && t0 < 0) begin t0 = c - 1; bus.req0 = 1'b0; end
      if (bus.done1 && t1 < 0) begin t1 = c - 1; bus.req1 = 1'b0; end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_done0_lat"}, t0, 3);
    check({tag, "_done1_lat"}, t1, 7);
    check({tag, "_nmoves"}, nm, 2);
    check({tag, "_first_word"}, first_in, d0);
    check({tag, "_second_word"}, second_in, d1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = OpNop; bus.op1 = OpNop;
    bus.data0 = '0; bus.data1 = '0;
    stk_top_word = '0;
    #3 rst = 1'b0;
    #1;
    check("rst_done0", bus.done0, 0);
    check("rst_done1", bus.done1, 0);
    check("rst_err", bus.err, 0);
    check("rst_move", stk_move, 0);
    check("rst_mode", stk_mode, 0);
    check("rst_in_word", stk_in_word, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_depth", depth, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single push then pop on the other port
    do_op("push_a", 0, OpPush, 4'hA, 3, 1'b0, 1, 1'b1);
    check("push_a_depth", depth, 1);
    check("push_a_empty", empty, 0);
    stk_top_word = 4'hA;
    do_op("pop_a", 1, OpPop, 4'h0, 3, 1'b0, 1, 1'b0);
    check("pop_a_rd", bus.rd_data, 4'hA);
    check("pop_a_depth", depth, 0);
    check("pop_a_empty", empty, 1);

    // Round-robin from reset
    apply_reset();
    dual_push("rr1", 4'h1, 4'h2);
    dual_push("rr2", 4'h3, 4'h4);
    check("rr_depth", depth, 4);

    // Fill to DEPTH and overflow
    for (int i = 5; i <= 8; i++) do_op("fill", 0, OpPush, 4'(i), 3, 1'b0, 1, 1'b1);
    check("fill_depth", depth, 8);
    check("fill_full", full, 1);
    do_op("ovf", 1, OpPush, 4'hF, 2, 1'b1, 0, 1'b1);
    check("ovf_depth", depth, 8);
    check("ovf_full", full, 1);

    // Underflow with a known rd_data value
    apply_reset();
    do_op("push5", 0, OpPush, 4'h5, 3, 1'b0, 1, 1'b1);
    stk_top_word = 4'h5;
    do_op("pop5", 1, OpPop, 4'h0, 3, 1'b0, 1, 1'b0);
    check("pop5_rd", bus.rd_data, 4'h5);
    stk_top_word = 4'h9;
    do_op("pop_empty", 0, OpPop, 4'h0, 2, 1'b1, 0, 1'b0);
    check("pop_empty_rd", bus.rd_data, 4'h5);
    check("pop_empty_depth", depth, 0);
    do_op("peek_empty", 1, OpPeek, 4'h0, 2, PeekEn, 0, 1'b0);
    check("peek_empty_rd", bus.rd_data, 4'h5);

    // Peek on a non-empty stack, then NOP
    do_op("push6", 0, OpPush, 4'h6, 3, 1'b0, 1, 1'b1);
    stk_top_word = 4'h6;
    do_op("peek6", 1, OpPeek, 4'h0, 2, 1'b0, 0, 1'b0);
    check("peek6_rd", bus.rd_data, PeekEn ? 4'h6 : 4'h5);
    check("peek6_depth", depth, 1);
    do_op("nop", 0, OpNop, 4'h0, 2, 1'b0, 0, 1'b0);
    check("nop_depth", depth, 1);

    // Reset during SETTLE of a push
    apply_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = OpPush; bus.data0 = 4'h7;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_move_high", stk_move, 1);
    check("mid_depth_before", depth, 1);
    rst = 1'b0;
    #1;
    check("mid_move_dropped", stk_move, 0);
    check("mid_depth_cleared", depth, 0);
    check("mid_empty", empty, 1);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.done0 || bus.done1) seen = 1'b1;
    end
    check("mid_no_done", seen, 0);
    do_op("post_rst_push", 0, OpPush, 4'hC, 3, 1'b0, 1, 1'b1);
    check("post_rst_depth", depth, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
